// File: rtl/imem_responder_pkg.sv
// imem_responder_pkg: state codes and shared constants for the instruction-memory responder.
package imem_responder_pkg;
  localparam logic [31:0] RESET_VECTOR  = 32'h8000_0000;
  localparam logic [31:0] IMEM_ERR_INST = 32'h0000_0000;
  typedef enum logic [1:0] {
    IMEM_IDLE = 2'd0,
    IMEM_WAIT = 2'd1,
    IMEM_RESP = 2'd2
  } imem_state_e;
endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x 32 word storage with a synchronous preload port and combinational read.
module imem_array #(
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_idx,
  input  logic [31:0]   ld_data,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (ld_en) mem[ld_idx] <= ld_data;
  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/imem_responder.sv
// imem_responder: single-outstanding fetch responder with programmable latency and address checking.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = RESET_VECTOR,
  parameter int unsigned LATENCY   = 2,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_inst,
  output logic          rsp_err,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_idx,
  input  logic [31:0]   ld_data
);
  imem_state_e   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d, inst_q, inst_d, off, rd_data;
  logic          err_q, err_d, dec_err;
  logic [AW-1:0] rd_idx;

  imem_array #(.DEPTH(DEPTH)) u_array (
    .clk    (clk),
    .ld_en  (ld_en),
    .ld_idx (ld_idx),
    .ld_data(ld_data),
    .rd_idx (rd_idx),
    .rd_data(rd_data)
  );

  // Wrap-around subtraction makes addresses below BASE_ADDR land far out of range.
  always_comb begin
    off     = addr_q - BASE_ADDR;
    dec_err = (addr_q[1:0] != 2'b00) || (off >= 32'(4 * DEPTH));
    rd_idx  = off[2 +: AW];
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    err_d   = err_q;
    unique case (state_q)
      IMEM_IDLE:
        if (req_valid) begin
          addr_d  = req_addr;
          cnt_d   = 4'(LATENCY);
          state_d = IMEM_WAIT;
        end
      IMEM_WAIT:
        if (cnt_q == 4'd0) begin
          inst_d  = dec_err ? IMEM_ERR_INST : rd_data;
          err_d   = dec_err;
          state_d = IMEM_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      IMEM_RESP:
        if (rsp_ready) state_d = IMEM_IDLE;
      default: state_d = IMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IMEM_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      inst_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end

  assign req_ready = (state_q == IMEM_IDLE);
  assign rsp_valid = (state_q == IMEM_RESP);
  assign rsp_inst  = inst_q;
  assign rsp_err   = err_q;
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: randomized fetch traffic on a LATENCY=2 and a LATENCY=0 responder against an address-rule memory model.
module tb_imem_responder;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 0, rst = 0, sel = 0;
  logic        req_valid = 0, rsp_ready = 0, ld_en = 0;
  logic [31:0] req_addr = 0, ld_data = 0;
  logic [9:0]  ld_idx = 0;
  logic        rr2, rv2, re2, rr0, rv0, re0, rqv2, rqv0, rr, rv, re;
  logic [31:0] ri2, ri0, ri;
  logic [31:0] mem_m [DEPTH];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  assign rqv2 = req_valid & ~sel;
  assign rqv0 = req_valid & sel;
  assign rr = sel ? rr0 : rr2;
  assign rv = sel ? rv0 : rv2;
  assign re = sel ? re0 : re2;
  assign ri = sel ? ri0 : ri2;

  imem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(rqv2), .req_ready(rr2), .req_addr(req_addr),
    .rsp_valid(rv2), .rsp_ready(rsp_ready), .rsp_inst(ri2), .rsp_err(re2),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data));

  imem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rqv0), .req_ready(rr0), .req_addr(req_addr),
    .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_inst(ri0), .rsp_err(re0),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  function automatic logic [32:0] model(input logic [31:0] a);
    logic [31:0] off = a - BASE;
    if (a[1:0] != 2'b00 || off >= 32'(4 * DEPTH)) return {1'b1, 32'h0};
    return {1'b0, mem_m[off / 4]};
  endfunction

  // ld_k selects which post-accept edge (0 = first) carries a preload write, -1 for none.
  task automatic fetch(input logic [31:0] a, input int hold, input int ld_k = -1,
                       input logic [9:0] li = 0, input logic [31:0] ld = 0);
    int lat = sel ? 0 : 2;
    int k;
    logic [32:0] e = model(a);
    check("idle_ready", rr, 1);
    req_addr = a; req_valid = 1; rsp_ready = (hold == 0);
    @(posedge clk); #1 req_valid = 0;
    check("busy_ready", rr, 0);
    for (k = 0; k < 40; k++) begin
      if (k == ld_k) begin ld_en = 1; ld_idx = li; ld_data = ld; end
      @(posedge clk); #1;
      if (k == ld_k) begin
        ld_en = 0;
        mem_m[li] = ld;
        if (k < lat) e = model(a);
      end
      if (rv) break;
    end
    check("latency", 32'(k + 1), 32'(lat + 1));
    check("inst", ri, e[31:0]);
    check("err", {31'b0, re}, {31'b0, e[32]});
    for (int h = 0; h < hold; h++) begin
      req_valid = 1; req_addr = a ^ 32'h10;
      @(posedge clk); #1;
      check("hold_valid", rv, 1);
      check("hold_inst", ri, e[31:0]);
      check("hold_ready", rr, 0);
    end
    rsp_ready = 1;
    @(posedge clk); #1 req_valid = 0;
    check("rsp_drop", rv, 0);
    check("no_accept", rr, 1);
  endtask

  initial begin
    logic [31:0] a, off;
    #2;
    check("rst_ready2", rr2, 1); check("rst_valid2", rv2, 0);
    check("rst_inst2", ri2, 0);  check("rst_err2", re2, 0);
    check("rst_ready0", rr0, 1); check("rst_valid0", rv0, 0);
    check("rst_inst0", ri0, 0);  check("rst_err0", re0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = (i == 0) ? 32'h0010_0093 : $urandom;
      ld_en = 1; ld_idx = 10'(i); ld_data = mem_m[i];
      @(posedge clk); #1;
    end
    ld_en = 0;
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    fetch(BASE, 0);
    fetch(BASE + 4, 4);
    fetch(BASE + 2, 0);
    fetch(BASE + 32'h1000, 1);
    fetch(32'h7FFF_FFFC, 0);
    fetch(BASE + 32'hFFC, 0);
    sel = 1;
    fetch(BASE, 0);
    fetch(BASE + 4, 0);
    sel = 0;
    fetch(BASE + 4, 0, 2, 10'd1, 32'hDEAD_BEEF);
    fetch(BASE + 4, 0);
    fetch(BASE + 8, 0, 0, 10'd2, 32'h1234_5678);
    sel = 1;
    fetch(BASE + 12, 0, 0, 10'd3, 32'hCAFE_F00D);
    sel = 0;
    req_addr = BASE + 8; req_valid = 1;
    @(posedge clk); #1 req_valid = 0;
    @(posedge clk); #2 rst = 0;
    #1;
    check("arst_ready", rr, 1);
    check("arst_valid", rv, 0);
    @(negedge clk) rst = 1;
    fetch(BASE + 8, 0);
    for (int n = 0; n < 60; n++) begin
      sel = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0, 1, 2: a = BASE + 4 * $urandom_range(0, DEPTH - 1);
        3:       a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
        4:       a = BASE + 32'(4 * DEPTH) + 4 * $urandom_range(0, 255);
        default: a = BASE - 4 * $urandom_range(1, 64);
      endcase
      off = a - BASE;
      if ($urandom_range(0, 2) == 0)
        fetch(a, $urandom_range(0, 3), $urandom_range(0, sel ? 0 : 2), off[11:2], $urandom);
      else
        fetch(a, $urandom_range(0, 3));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
